// File: rtl/operand_fetch_if.sv
// operand_fetch_if: instruction, register-file, writeback and issue signals of operand_fetch
interface operand_fetch_if #(
  parameter int BIT_NUMBER  = 64,
  parameter int ADDR_NUMBER = 5
);
  logic                   in_valid, in_ready;
  logic [ADDR_NUMBER-1:0] in_src_addr_1, in_src_addr_2, in_dest_addr;
  logic                   in_uses_src_1, in_uses_src_2, in_writes_dest;
  logic [7:0]             in_opcode;
  logic [ADDR_NUMBER-1:0] rf_src_addr_1, rf_src_addr_2;
  logic [BIT_NUMBER-1:0]  rf_data_1, rf_data_2;
  logic                   wb_valid;
  logic [ADDR_NUMBER-1:0] wb_dest_addr;
  logic                   out_valid, out_ready;
  logic [BIT_NUMBER-1:0]  out_data_1, out_data_2;
  logic [ADDR_NUMBER-1:0] out_dest_addr;
  logic                   out_writes_dest;
  logic [7:0]             out_opcode;
  logic                   err_illegal_addr;
  logic [15:0]            stall_count;
  modport slave (
    input  in_valid, in_src_addr_1, in_src_addr_2, in_dest_addr,
           in_uses_src_1, in_uses_src_2, in_writes_dest, in_opcode,
           rf_data_1, rf_data_2, wb_valid, wb_dest_addr, out_ready,
    output in_ready, rf_src_addr_1, rf_src_addr_2, out_valid, out_data_1, out_data_2,
           out_dest_addr, out_writes_dest, out_opcode, err_illegal_addr, stall_count
  );
  modport master (
    output in_valid, in_src_addr_1, in_src_addr_2, in_dest_addr,
           in_uses_src_1, in_uses_src_2, in_writes_dest, in_opcode,
           rf_data_1, rf_data_2, wb_valid, wb_dest_addr, out_ready,
    input  in_ready, rf_src_addr_1, rf_src_addr_2, out_valid, out_data_1, out_data_2,
           out_dest_addr, out_writes_dest, out_opcode, err_illegal_addr, stall_count
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: scoreboarded operand fetch stage with hazard stall, register-file read and output hold
module operand_fetch #(
  parameter int BIT_NUMBER      = 64,
  parameter int ADDR_NUMBER     = 5,
  parameter int REGISTER_NUMBER = 16
) (
  input logic          clk,
  input logic          reset,
  operand_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HAZARD, READ, VALID} state_t;
  state_t                     state, state_n;
  logic [ADDR_NUMBER-1:0]     src_1, src_2, dest;
  logic                       uses_1, uses_2, writes;
  logic [7:0]                 opcode;
  logic [REGISTER_NUMBER-1:0] pending, need, clr, set;
  logic                       accept, illegal, hazard;
  // out-of-range addresses map to an all-zero mask, which doubles as the legality test
  function automatic logic [REGISTER_NUMBER-1:0] onehot(input logic [ADDR_NUMBER-1:0] a);
    return {{(REGISTER_NUMBER-1){1'b0}}, 1'b1} << a;
  endfunction
  assign bus.in_ready      = state == IDLE;
  assign bus.out_valid     = state == VALID;
  assign bus.rf_src_addr_1 = src_1;
  assign bus.rf_src_addr_2 = src_2;
  always_comb begin
    accept  = bus.in_valid && state == IDLE;
    illegal = (bus.in_uses_src_1 && ~|onehot(bus.in_src_addr_1)) ||
              (bus.in_uses_src_2 && ~|onehot(bus.in_src_addr_2)) ||
              (bus.in_writes_dest && ~|onehot(bus.in_dest_addr));
    need    = (uses_1 ? onehot(src_1) : '0) | (uses_2 ? onehot(src_2) : '0) | (writes ? onehot(dest) : '0);
    clr     = bus.wb_valid ? onehot(bus.wb_dest_addr) : '0;
    hazard  = |(need & pending & ~clr);
    set     = (state == HAZARD && !hazard && writes) ? onehot(dest) : '0;
    state_n = state == IDLE   ? ((accept && !illegal) ? HAZARD : IDLE) :
              state == HAZARD ? (hazard ? HAZARD : READ) :
              state == READ   ? VALID :
              (bus.out_ready ? IDLE : VALID);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      pending              <= '0;
      src_1                <= '0;
      src_2                <= '0;
      dest                 <= '0;
      uses_1               <= 1'b0;
      uses_2               <= 1'b0;
      writes               <= 1'b0;
      opcode               <= '0;
      bus.out_data_1       <= '0;
      bus.out_data_2       <= '0;
      bus.out_dest_addr    <= '0;
      bus.out_writes_dest  <= 1'b0;
      bus.out_opcode       <= '0;
      bus.err_illegal_addr <= 1'b0;
      bus.stall_count      <= '0;
    end else begin
      state                <= state_n;
      pending              <= (pending & ~clr) | set;
      bus.err_illegal_addr <= accept && illegal;
      if (state == HAZARD && hazard && ~&bus.stall_count)
        bus.stall_count <= bus.stall_count + 16'd1;
      if (accept) begin
        src_1  <= bus.in_src_addr_1;
        src_2  <= bus.in_src_addr_2;
        dest   <= bus.in_dest_addr;
        uses_1 <= bus.in_uses_src_1;
        uses_2 <= bus.in_uses_src_2;
        writes <= bus.in_writes_dest;
        opcode <= bus.in_opcode;
      end
      if (state == READ) begin
        bus.out_data_1      <= uses_1 ? bus.rf_data_1 : '0;
        bus.out_data_2      <= uses_2 ? bus.rf_data_2 : '0;
        bus.out_dest_addr   <= dest;
        bus.out_writes_dest <= writes;
        bus.out_opcode      <= opcode;
      end
    end
  end
endmodule
